agendador_alarme: RTL and testbench
===================================

# agendador_alarme

Alarm scheduler that drives the `alarme` and `dia_util` inputs of the wake-up FSM from a minute-of-day clock and a programmed alarm time. It adds snooze, ring timeout and dismiss sequencing, with the wake-up FSM's `desligar` fed back as the dismiss input. It sits between the minute-strobe generator and the wake-up FSM.

## Interface
- `ALARME_PADRAO`, 420: alarm minute-of-day after reset (07:00)
- `SONECA_MIN`, 9: snooze length in minutes, 1..15
- `MAX_SONECAS`, 3: snoozes allowed per alarm event, 0..3
- `TEMPO_TOQUE`, 5: minutes of unanswered ringing before auto-stop, 1..15

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `tick_min`  in  1  one-cycle minute strobe
- `set_tempo_we`  in  1  load current time
- `set_minuto`  in  11  minute-of-day to load, 0..1439
- `set_dia`  in  3  day to load; 0=domingo..6=sabado
- `cfg_we`  in  1  write alarm time
- `cfg_minuto`  in  11  alarm minute-of-day
- `cfg_ativo`  in  1  alarm enable, level
- `soneca`  in  1  snooze request, one-cycle pulse
- `desligar`  in  1  dismiss, level
- `alarme`  out  1  ringing
- `dia_util`  out  1  current day is 1..5
- `minuto_atual`  out  11  current minute-of-day
- `dia_atual`  out  3  current day
- `sonecas`  out  2  snoozes used in current event

## Operation
- Clock: on `tick_min`, `minuto_atual` increments. 1439→0 wraps, and `dia_atual` advances (6→0).
- `set_tempo_we` loads `set_minuto`/`set_dia` and overrides `tick_min` in the same cycle. A load never produces an alarm match.
- `set_minuto` ≥1440 or `set_dia` = 7 is clamped to 1439/6.
- `cfg_we` latches `cfg_minuto` into the alarm register. Values ≥1440 are ignored and the old value is kept.
- `dia_util` is combinational from `dia_atual`.
- Match condition: `tick_min` = 1, no `set_tempo_we`, and the post-increment minute equals the alarm register.
- FSM states: OCIOSO, TOCANDO, SONECA, ENCERRADO.
  - OCIOSO: match with `cfg_ativo` = 1 → TOCANDO. `sonecas` clears to 0 and the ring counter loads `TEMPO_TOQUE`.
  - TOCANDO: `alarme` = 1.
    - Priority is `desligar` > `soneca` > timeout.
    - `desligar` → ENCERRADO.
    - `soneca` with `sonecas` < `MAX_SONECAS` → SONECA. The snooze counter loads `SONECA_MIN` and `sonecas` increments.
    - `soneca` at the snooze limit is ignored.
    - Each `tick_min` decrements the ring counter. A tick at count 1 → ENCERRADO.
  - SONECA: `alarme` = 0.
    - Each `tick_min` decrements the snooze counter. A tick at count 1 → TOCANDO, and the ring counter reloads.
    - `desligar` → ENCERRADO.
    - `soneca` is ignored.
  - ENCERRADO: `alarme` = 0. Next `tick_min` → OCIOSO. `sonecas` holds until the next event.
- `cfg_ativo` = 0 forces OCIOSO from any state. This takes priority over all transitions.
- A match outside OCIOSO is ignored.
- `cfg_we` during TOCANDO/SONECA does not alter the current event.

## Timing
- Reset values:
  - state OCIOSO
  - `alarme` 0
  - `sonecas` 0
  - `minuto_atual` 0
  - `dia_atual` 0, so `dia_util` = 0
  - alarm register `ALARME_PADRAO`
  - all counters 0
- All outputs are registered except `dia_util`.
- Alarm start: `alarme` rises on the same edge that updates `minuto_atual` for the matching tick, so latency is 1 cycle.
- Dismiss and snooze: `alarme` falls 1 cycle after the `desligar` or `soneca` sample edge.
- `cfg_ativo` falling: `alarme` falls 1 cycle after the sample edge.
- `reset` mid-event: 1 cycle to the reset state. Stored alarm time returns to `ALARME_PADRAO`.
- Snooze duration is counted in `tick_min` strobes. The first strobe after entering SONECA counts, so re-ring happens on the `SONECA_MIN`th tick.
- `desligar` held high across a match: the FSM enters TOCANDO, then ENCERRADO on the next cycle. `alarme` is high for exactly 1 cycle.

## Structure
- Package `agendador_pkg`:
  - state encoding (2-bit)
  - `MIN_POR_DIA` = 1440
  - day constants `DOMINGO`..`SABADO`
  - width localparams (11-bit minute, 3-bit day)
- Sub-module `relogio_dia`:
  - minute/day counter with load and wrap
  - outputs `minuto_atual`, `dia_atual`, and a registered-next-minute compare input
- FSM and the snooze/ring counters live in the top module.

## Test plan
- Reset, time load 06:59 on day 1, `cfg_ativo` = 1, default alarm. One `tick_min` → `minuto_atual` = 420 and `alarme` = 1 on that edge; `dia_util` = 1.
- Ringing, `soneca` pulse ×3 (each re-ring after 9 ticks) → `sonecas` = 3. A 4th `soneca` is ignored, `alarme` stays 1. `desligar` → `alarme` 0 next cycle.
- Ringing with no input → `alarme` drops after 5 ticks. State is ENCERRADO, then OCIOSO on tick 6.
- Load 23:59 on day 6, one tick → `minuto_atual` = 0, `dia_atual` = 0, `dia_util` = 0.
- Alarm at 0 with time 23:59, tick → match across wrap, `alarme` = 1.
- Edge cases:
  - `cfg_ativo` dropped during SONECA → `alarme` stays 0 after the snooze expires.
  - `cfg_we` with 1500 → alarm register unchanged.
  - `set_tempo_we` and `tick_min` in the same cycle → loaded value wins, no alarm.

Source files
------------

// File: rtl/agendador_alarme_pkg.sv
// Shared types and constants for the alarm scheduler: minute/day widths,
// weekday codes and the alarm sequencing states.
package agendador_pkg;

  localparam int MIN_POR_DIA  = 1440;
  localparam int LARG_MINUTO  = 11;
  localparam int LARG_DIA     = 3;

  localparam logic [LARG_DIA-1:0] DOMINGO = 3'd0;
  localparam logic [LARG_DIA-1:0] SEGUNDA = 3'd1;
  localparam logic [LARG_DIA-1:0] TERCA   = 3'd2;
  localparam logic [LARG_DIA-1:0] QUARTA  = 3'd3;
  localparam logic [LARG_DIA-1:0] QUINTA  = 3'd4;
  localparam logic [LARG_DIA-1:0] SEXTA   = 3'd5;
  localparam logic [LARG_DIA-1:0] SABADO  = 3'd6;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    TOCANDO   = 2'd1,
    SONECA    = 2'd2,
    ENCERRADO = 2'd3
  } estado_t;

  function automatic logic eh_dia_util(input logic [LARG_DIA-1:0] dia);
    return (dia >= SEGUNDA) && (dia <= SEXTA);
  endfunction

endpackage

// File: rtl/agendador_alarme_if.sv
// Control/status bundle between the minute-strobe side and the scheduler.
// master drives time, configuration and user requests; slave is the scheduler.
interface agendador_alarme_if;
  import agendador_pkg::*;

  logic                   tick_min;
  logic                   set_tempo_we;
  logic [LARG_MINUTO-1:0] set_minuto;
  logic [LARG_DIA-1:0]    set_dia;
  logic                   cfg_we;
  logic [LARG_MINUTO-1:0] cfg_minuto;
  logic                   cfg_ativo;
  logic                   soneca;
  logic                   desligar;
  logic                   alarme;
  logic                   dia_util;
  logic [LARG_MINUTO-1:0] minuto_atual;
  logic [LARG_DIA-1:0]    dia_atual;
  logic [1:0]             sonecas;

  modport master (
    output tick_min, set_tempo_we, set_minuto, set_dia,
    output cfg_we, cfg_minuto, cfg_ativo, soneca, desligar,
    input  alarme, dia_util, minuto_atual, dia_atual, sonecas
  );

  modport slave (
    input  tick_min, set_tempo_we, set_minuto, set_dia,
    input  cfg_we, cfg_minuto, cfg_ativo, soneca, desligar,
    output alarme, dia_util, minuto_atual, dia_atual, sonecas
  );

endinterface

// File: rtl/agendador_alarme_relogio_dia.sv
// Minute-of-day and weekday counter with clamped load. Keeps the following
// minute precomputed in a register so the alarm compare needs no adder.
module relogio_dia
  import agendador_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick_min,
  input  logic                   set_tempo_we,
  input  logic [LARG_MINUTO-1:0] set_minuto,
  input  logic [LARG_DIA-1:0]    set_dia,
  output logic [LARG_MINUTO-1:0] minuto_atual,
  output logic [LARG_DIA-1:0]    dia_atual,
  output logic [LARG_MINUTO-1:0] proximo_minuto
);

  localparam logic [LARG_MINUTO-1:0] ULTIMO_MINUTO = LARG_MINUTO'(MIN_POR_DIA - 1);

  logic [LARG_MINUTO-1:0] carga_minuto;
  logic [LARG_DIA-1:0]    carga_dia;

  function automatic logic [LARG_MINUTO-1:0] seguinte(input logic [LARG_MINUTO-1:0] m);
    return (m == ULTIMO_MINUTO) ? '0 : m + 1'b1;
  endfunction

  assign carga_minuto = (set_minuto > ULTIMO_MINUTO) ? ULTIMO_MINUTO : set_minuto;
  assign carga_dia    = (set_dia > SABADO) ? SABADO : set_dia;

  // The day advances on the tick whose new minute is midnight.
  always_ff @(posedge clock) begin
    if (reset) begin
      minuto_atual   <= '0;
      dia_atual      <= DOMINGO;
      proximo_minuto <= LARG_MINUTO'(1);
    end else if (set_tempo_we) begin
      minuto_atual   <= carga_minuto;
      dia_atual      <= carga_dia;
      proximo_minuto <= seguinte(carga_minuto);
    end else if (tick_min) begin
      minuto_atual   <= proximo_minuto;
      proximo_minuto <= seguinte(proximo_minuto);
      if (proximo_minuto == '0) begin
        dia_atual <= (dia_atual == SABADO) ? DOMINGO : dia_atual + 1'b1;
      end
    end
  end

endmodule

// File: rtl/agendador_alarme.sv
// Alarm scheduler: compares the running clock against the programmed alarm
// and sequences ringing, snooze, ring timeout and dismiss.
module agendador_alarme
  import agendador_pkg::*;
#(
  parameter int ALARME_PADRAO = 420,
  parameter int SONECA_MIN    = 9,
  parameter int MAX_SONECAS   = 3,
  parameter int TEMPO_TOQUE   = 5
) (
  input  logic               clock,
  input  logic               reset,
  agendador_alarme_if.slave  bus
);

  localparam logic [LARG_MINUTO-1:0] ALARME_INICIAL = LARG_MINUTO'(ALARME_PADRAO);
  localparam logic [3:0]             CARGA_SONECA   = 4'(SONECA_MIN);
  localparam logic [3:0]             CARGA_TOQUE    = 4'(TEMPO_TOQUE);
  localparam logic [1:0]             LIMITE_SONECAS = 2'(MAX_SONECAS);

  estado_t                estado;
  logic [LARG_MINUTO-1:0] minuto_alarme;
  logic [LARG_MINUTO-1:0] minuto_atual;
  logic [LARG_DIA-1:0]    dia_atual;
  logic [LARG_MINUTO-1:0] proximo_minuto;
  logic [3:0]             cont_toque;
  logic [3:0]             cont_soneca;
  logic [1:0]             sonecas;
  logic                   alarme;
  logic                   casou;

  relogio_dia u_relogio (
    .clock          (clock),
    .reset          (reset),
    .tick_min       (bus.tick_min),
    .set_tempo_we   (bus.set_tempo_we),
    .set_minuto     (bus.set_minuto),
    .set_dia        (bus.set_dia),
    .minuto_atual   (minuto_atual),
    .dia_atual      (dia_atual),
    .proximo_minuto (proximo_minuto)
  );

  // A time load suppresses the match even when it coincides with a tick.
  assign casou = bus.tick_min && !bus.set_tempo_we && (proximo_minuto == minuto_alarme);

  always_ff @(posedge clock) begin
    if (reset) begin
      minuto_alarme <= ALARME_INICIAL;
    end else if (bus.cfg_we && (bus.cfg_minuto < LARG_MINUTO'(MIN_POR_DIA))) begin
      minuto_alarme <= bus.cfg_minuto;
    end
  end

  // Disabling the alarm wins over every transition; within ringing the
  // order is dismiss, then snooze, then timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= OCIOSO;
      alarme      <= 1'b0;
      sonecas     <= 2'd0;
      cont_toque  <= 4'd0;
      cont_soneca <= 4'd0;
    end else if (!bus.cfg_ativo) begin
      estado <= OCIOSO;
      alarme <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (casou) begin
            estado     <= TOCANDO;
            alarme     <= 1'b1;
            sonecas    <= 2'd0;
            cont_toque <= CARGA_TOQUE;
          end
        end
        TOCANDO: begin
          if (bus.desligar) begin
            estado <= ENCERRADO;
            alarme <= 1'b0;
          end else if (bus.soneca && (sonecas < LIMITE_SONECAS)) begin
            estado      <= SONECA;
            alarme      <= 1'b0;
            cont_soneca <= CARGA_SONECA;
            sonecas     <= sonecas + 1'b1;
          end else if (bus.tick_min) begin
            if (cont_toque == 4'd1) begin
              estado <= ENCERRADO;
              alarme <= 1'b0;
            end
            cont_toque <= cont_toque - 1'b1;
          end
        end
        SONECA: begin
          if (bus.desligar) begin
            estado <= ENCERRADO;
          end else if (bus.tick_min) begin
            if (cont_soneca == 4'd1) begin
              estado     <= TOCANDO;
              alarme     <= 1'b1;
              cont_toque <= CARGA_TOQUE;
            end
            cont_soneca <= cont_soneca - 1'b1;
          end
        end
        ENCERRADO: begin
          if (bus.tick_min) begin
            estado <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.alarme       = alarme;
  assign bus.sonecas      = sonecas;
  assign bus.minuto_atual = minuto_atual;
  assign bus.dia_atual    = dia_atual;
  assign bus.dia_util     = eh_dia_util(dia_atual);

endmodule

// File: tb/tb_agendador_alarme.sv
// Scoreboard bench for agendador_alarme: every cycle a reference model pushes
// the expected outputs, a monitor pops and compares them after the clock edge.
module tb_agendador_alarme;
  import agendador_pkg::*;

  localparam int P_ALARME = 420;
  localparam int P_SONECA = 9;
  localparam int P_MAXSON = 3;
  localparam int P_TOQUE  = 5;

  typedef struct packed {
    logic        alarme;
    logic        dia_util;
    logic [10:0] minuto;
    logic [2:0]  dia;
    logic [1:0]  sonecas;
  } saida_t;

  logic clock;
  logic reset;
  agendador_alarme_if bus ();

  agendador_alarme #(
    .ALARME_PADRAO (P_ALARME),
    .SONECA_MIN    (P_SONECA),
    .MAX_SONECAS   (P_MAXSON),
    .TEMPO_TOQUE   (P_TOQUE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int     comparados = 0;
  int     divergentes = 0;
  saida_t fila[$];

  // Reference model: event-level view of the alarm (idle/ringing/snoozing/finished).
  int  m_min, m_dia, m_alarme, m_son, m_resta_toque, m_resta_soneca;
  bit  m_tocando, m_dormindo, m_encerrado;

  task automatic modeloPasso();
    bit     casa;
    saida_t e;
    if (reset) begin
      m_min = 0; m_dia = 0; m_alarme = P_ALARME; m_son = 0;
      m_tocando = 0; m_dormindo = 0; m_encerrado = 0;
      m_resta_toque = 0; m_resta_soneca = 0;
    end else begin
      casa = bus.tick_min && !bus.set_tempo_we && (((m_min + 1) % 1440) == m_alarme);
      if (bus.set_tempo_we) begin
        m_min = (int'(bus.set_minuto) > 1439) ? 1439 : int'(bus.set_minuto);
        m_dia = (int'(bus.set_dia) > 6) ? 6 : int'(bus.set_dia);
      end else if (bus.tick_min) begin
        m_min = (m_min + 1) % 1440;
        if (m_min == 0) m_dia = (m_dia + 1) % 7;
      end
      if (bus.cfg_we && int'(bus.cfg_minuto) < 1440) m_alarme = int'(bus.cfg_minuto);
      if (!bus.cfg_ativo) begin
        m_tocando = 0; m_dormindo = 0; m_encerrado = 0;
      end else if (m_tocando) begin
        if (bus.desligar) begin
          m_tocando = 0; m_encerrado = 1;
        end else if (bus.soneca && m_son < P_MAXSON) begin
          m_tocando = 0; m_dormindo = 1; m_son++; m_resta_soneca = P_SONECA;
        end else if (bus.tick_min) begin
          m_resta_toque--;
          if (m_resta_toque == 0) begin m_tocando = 0; m_encerrado = 1; end
        end
      end else if (m_dormindo) begin
        if (bus.desligar) begin
          m_dormindo = 0; m_encerrado = 1;
        end else if (bus.tick_min) begin
          m_resta_soneca--;
          if (m_resta_soneca == 0) begin
            m_dormindo = 0; m_tocando = 1; m_resta_toque = P_TOQUE;
          end
        end
      end else if (m_encerrado) begin
        if (bus.tick_min) m_encerrado = 0;
      end else if (casa) begin
        m_tocando = 1; m_son = 0; m_resta_toque = P_TOQUE;
      end
    end
    e.alarme   = m_tocando;
    e.dia_util = (m_dia >= 1) && (m_dia <= 5);
    e.minuto   = 11'(m_min);
    e.dia      = 3'(m_dia);
    e.sonecas  = 2'(m_son);
    fila.push_back(e);
  endtask

  // Called at a falling edge with inputs already driven; one-shot inputs clear afterwards.
  task automatic applyStimulus();
    modeloPasso();
    @(negedge clock);
    bus.tick_min     = 1'b0;
    bus.soneca       = 1'b0;
    bus.set_tempo_we = 1'b0;
    bus.cfg_we       = 1'b0;
  endtask

  task automatic ciclo();
    applyStimulus();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_min = 1'b1;
      applyStimulus();
      applyStimulus();
    end
  endtask

  task automatic carrega(input int minuto, input int dia);
    bus.set_tempo_we = 1'b1;
    bus.set_minuto   = 11'(minuto);
    bus.set_dia      = 3'(dia);
    applyStimulus();
  endtask

  task automatic checkOutput(input string nome, input int got, input int exp);
    comparados++;
    if (got != exp) begin
      divergentes++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
    end
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  initial begin
    saida_t e, a;
    forever begin
      @(posedge clock);
      #1;
      if (fila.size() > 0) begin
        e = fila.pop_front();
        a = '{bus.alarme, bus.dia_util, bus.minuto_atual, bus.dia_atual, bus.sonecas};
        comparados++;
        if (a !== e) begin
          divergentes++;
          $display("[TB] FAIL scoreboard: got alarme=%0b util=%0b min=%0d dia=%0d son=%0d expected alarme=%0b util=%0b min=%0d dia=%0d son=%0d at %0t",
                   a.alarme, a.dia_util, a.minuto, a.dia, a.sonecas,
                   e.alarme, e.dia_util, e.minuto, e.dia, e.sonecas, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus.tick_min     = 1'b0;
    bus.set_tempo_we = 1'b0;
    bus.set_minuto   = '0;
    bus.set_dia      = '0;
    bus.cfg_we       = 1'b0;
    bus.cfg_minuto   = '0;
    bus.cfg_ativo    = 1'b1;
    bus.soneca       = 1'b0;
    bus.desligar     = 1'b0;
    @(negedge clock);
    ciclo();
    ciclo();
    reset = 1'b0;
    checkOutput("reset_alarme", int'(bus.alarme), 0);
    checkOutput("reset_minuto", int'(bus.minuto_atual), 0);
    checkOutput("reset_dia", int'(bus.dia_atual), 0);
    checkOutput("reset_util", int'(bus.dia_util), 0);
    checkOutput("reset_sonecas", int'(bus.sonecas), 0);

    carrega(419, 1);
    checkOutput("carga_minuto", int'(bus.minuto_atual), 419);
    ticks(1);
    checkOutput("dispara_minuto", int'(bus.minuto_atual), 420);
    checkOutput("dispara_alarme", int'(bus.alarme), 1);
    checkOutput("dispara_util", int'(bus.dia_util), 1);

    for (int k = 1; k <= 3; k++) begin
      bus.soneca = 1'b1;
      ciclo();
      checkOutput("soneca_cala", int'(bus.alarme), 0);
      checkOutput("soneca_conta", int'(bus.sonecas), k);
      ticks(P_SONECA - 1);
      checkOutput("soneca_ainda", int'(bus.alarme), 0);
      ticks(1);
      checkOutput("soneca_volta", int'(bus.alarme), 1);
    end
    bus.soneca = 1'b1;
    ciclo();
    checkOutput("soneca_limite", int'(bus.alarme), 1);
    checkOutput("soneca_limite_n", int'(bus.sonecas), 3);
    bus.desligar = 1'b1;
    ciclo();
    checkOutput("desligar", int'(bus.alarme), 0);
    bus.desligar = 1'b0;
    ticks(1);

    carrega(419, 2);
    ticks(1);
    checkOutput("timeout_inicio", int'(bus.alarme), 1);
    checkOutput("timeout_zera_son", int'(bus.sonecas), 0);
    ticks(P_TOQUE - 1);
    checkOutput("timeout_antes", int'(bus.alarme), 1);
    ticks(1);
    checkOutput("timeout_fim", int'(bus.alarme), 0);
    ticks(1);
    carrega(419, 2);
    ticks(1);
    checkOutput("timeout_reentra", int'(bus.alarme), 1);
    bus.desligar = 1'b1;
    ciclo();
    bus.desligar = 1'b0;
    ticks(1);

    carrega(1439, 6);
    ticks(1);
    checkOutput("virada_minuto", int'(bus.minuto_atual), 0);
    checkOutput("virada_dia", int'(bus.dia_atual), 0);
    checkOutput("virada_util", int'(bus.dia_util), 0);
    checkOutput("virada_alarme", int'(bus.alarme), 0);

    bus.cfg_we = 1'b1;
    bus.cfg_minuto = 11'd0;
    ciclo();
    carrega(1439, 3);
    ticks(1);
    checkOutput("meianoite_alarme", int'(bus.alarme), 1);
    checkOutput("meianoite_dia", int'(bus.dia_atual), 4);
    bus.desligar = 1'b1;
    ciclo();
    bus.desligar = 1'b0;
    ticks(1);

    carrega(1439, 3);
    ticks(1);
    bus.soneca = 1'b1;
    ciclo();
    bus.cfg_ativo = 1'b0;
    ciclo();
    ticks(P_SONECA + 3);
    checkOutput("inativo_soneca", int'(bus.alarme), 0);
    bus.cfg_ativo = 1'b1;
    ciclo();

    bus.cfg_we = 1'b1;
    bus.cfg_minuto = 11'd1500;
    ciclo();
    carrega(1439, 3);
    ticks(1);
    checkOutput("cfg_invalida", int'(bus.alarme), 1);
    bus.desligar = 1'b1;
    ciclo();
    bus.desligar = 1'b0;
    ticks(1);

    carrega(1439, 0);
    bus.tick_min = 1'b1;
    carrega(1439, 0);
    checkOutput("carga_tick_min", int'(bus.minuto_atual), 1439);
    checkOutput("carga_tick_alarme", int'(bus.alarme), 0);

    carrega(2000, 7);
    checkOutput("clamp_minuto", int'(bus.minuto_atual), 1439);
    checkOutput("clamp_dia", int'(bus.dia_atual), 6);

    bus.desligar = 1'b1;
    bus.tick_min = 1'b1;
    ciclo();
    checkOutput("desligar_preso_1", int'(bus.alarme), 1);
    ciclo();
    checkOutput("desligar_preso_2", int'(bus.alarme), 0);
    bus.desligar = 1'b0;
    ticks(1);

    for (int n = 0; n < 3000; n++) begin
      bus.tick_min = ($urandom_range(0, 1) == 0);
      bus.soneca   = ($urandom_range(0, 7) == 0);
      if (bus.desligar) bus.desligar = ($urandom_range(0, 2) != 0);
      else              bus.desligar = ($urandom_range(0, 39) == 0);
      if (bus.cfg_ativo) bus.cfg_ativo = ($urandom_range(0, 149) != 0);
      else               bus.cfg_ativo = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) begin
        bus.cfg_we = 1'b1;
        if ($urandom_range(0, 3) == 0) bus.cfg_minuto = 11'($urandom_range(0, 2047));
        else bus.cfg_minuto = 11'((m_min + int'($urandom_range(1, 4))) % 1440);
      end
      if ($urandom_range(0, 59) == 0) begin
        bus.set_tempo_we = 1'b1;
        bus.set_minuto   = 11'($urandom_range(0, 2047));
        bus.set_dia      = 3'($urandom_range(0, 7));
      end
      reset = ($urandom_range(0, 799) == 0);
      applyStimulus();
    end
    reset = 1'b0;
    bus.tick_min = 1'b0;
    ciclo();
    @(negedge clock);
    checkOutput("fila_vazia", fila.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
    $finish;
  end

endmodule
